// File: rtl/rw_seq_pkg.sv
// Shared types and defaults for the resumption-device step sequencer.
package rw_seq_pkg;

    // Controller states; the encoding is fixed so it can be probed externally.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DEVRST = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } seq_state_t;

    // Default width of the completed-step counter.
    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/rw_step_sequencer_out_reg.sv
// Output holding register with a valid/ready handshake. A load in the same
// cycle as a consumer accept keeps valid high with the new word, so a
// stalled consumer never loses a step result.
module rw_out_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data
);

    logic         valid_reg;
    logic [W-1:0] data_reg;

    // Capture a new result, drain on accept, or discard on clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (clear) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            data_reg  <= din;
        end else if (ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;

endmodule

// File: rtl/rw_step_sequencer.sv
// Sequencer for one compiled resumption device: gates each device step on
// the input and output stream handshakes, detects halt, counts steps and
// restarts the device on command.
// Optional macro STEP_BUDGET_EN adds a step budget (budget / budget_hit).
module rw_step_sequencer
    import rw_seq_pkg::*;
#(
    parameter int IN_W  = 1,
    parameter int OUT_W = 1,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             restart,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    output logic [IN_W-1:0]  dev_in,
    output logic             dev_step,
    output logic             dev_rst,
    input  logic [OUT_W-1:0] dev_out,
    input  logic             dev_continue,
    output logic             halted,
    output logic [CNT_W-1:0] step_count,
`ifdef STEP_BUDGET_EN
    input  logic [CNT_W-1:0] budget,
    output logic             budget_hit,
`endif
    output logic             busy
);

    seq_state_t       state_reg;
    logic [CNT_W-1:0] step_count_reg;
    logic             halted_reg;
    logic             step_fire;
    logic             step_block;
    logic             out_clear;

`ifdef STEP_BUDGET_EN
    // Budget reached: hold the device until the budget is raised or cleared.
    assign budget_hit = !rst && (state_reg == RUN) && !restart &&
                        (budget != '0) && (step_count_reg == budget);
    assign step_block = budget_hit;
`else
    assign step_block = 1'b0;
`endif

    // A step needs a word upstream and room downstream (or a same-cycle drain).
    assign step_fire = !rst && (state_reg == RUN) && !restart && in_valid &&
                       (!out_valid || out_ready) && !step_block;

    assign in_ready   = step_fire;
    assign dev_step   = step_fire;
    assign dev_in     = in_data;
    assign dev_rst    = rst || (state_reg == DEVRST);
    assign busy       = (state_reg == RUN);
    assign halted     = halted_reg;
    assign step_count = step_count_reg;

    // A restart discards any pending result immediately.
    assign out_clear = restart || (state_reg == DEVRST);

    rw_out_reg #(
        .W (OUT_W)
    ) u_out_reg (
        .clk   (clk),
        .rst   (rst),
        .clear (out_clear),
        .load  (step_fire),
        .din   (dev_out),
        .ready (out_ready),
        .valid (out_valid),
        .data  (out_data)
    );

    // Controller FSM with step counter and halt flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            step_count_reg <= '0;
            halted_reg     <= 1'b0;
        end else if (restart) begin
            state_reg      <= DEVRST;
            step_count_reg <= '0;
            halted_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= RUN;
                    end
                end
                DEVRST: begin
                    step_count_reg <= '0;
                    halted_reg     <= 1'b0;
                    state_reg      <= RUN;
                end
                RUN: begin
                    if (step_fire) begin
                        step_count_reg <= step_count_reg + CNT_W'(1);
                        if (!dev_continue) begin
                            state_reg  <= HALTED;
                            halted_reg <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    state_reg <= HALTED;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rw_step_sequencer.sv
// Self-checking bench for rw_step_sequencer: a cycle-level reference model
// checked every cycle, plus directed literal expectations.
module tb_rw_step_sequencer;

    localparam int IN_W  = 4;
    localparam int OUT_W = 4;
    localparam int CNT_W = 3;

    localparam int M_IDLE   = 0;
    localparam int M_DEVRST = 1;
    localparam int M_RUN    = 2;
    localparam int M_HALTED = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             restart;
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             in_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_ready;
    logic [IN_W-1:0]  dev_in;
    logic             dev_step;
    logic             dev_rst;
    logic [OUT_W-1:0] dev_out;
    logic             dev_continue;
    logic             halted;
    logic [CNT_W-1:0] step_count;
    logic             busy;
    logic [CNT_W-1:0] budget;
    logic             budget_hit;
    logic             halt_arm;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rw_step_sequencer #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .restart      (restart),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .dev_in       (dev_in),
        .dev_step     (dev_step),
        .dev_rst      (dev_rst),
        .dev_out      (dev_out),
        .dev_continue (dev_continue),
        .halted       (halted),
        .step_count   (step_count),
`ifdef STEP_BUDGET_EN
        .budget       (budget),
        .budget_hit   (budget_hit),
`endif
        .busy         (busy)
    );

`ifndef STEP_BUDGET_EN
    assign budget_hit = 1'b0;
`endif

    // Toy resumption device: tag counts steps, output is input XOR tag,
    // and it halts on the step taken with tag==2 while halt_arm is set.
    logic [3:0] tag;
    always @(posedge clk) begin
        if (dev_rst) tag <= 4'd0;
        else if (dev_step) tag <= tag + 4'd1;
    end
    assign dev_out      = dev_in ^ tag;
    assign dev_continue = !(halt_arm && tag == 4'd2);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state.
    int         m_mode;
    logic       m_ov;
    logic [3:0] m_od;
    int         m_cnt;
    logic       m_halted;

    // Compare DUT against the model mid-cycle, then advance the model.
    always @(negedge clk) begin
        logic step, hit;
        if (rst) begin
            check("dev_rst_during_rst", 32'(dev_rst), 32'd1);
            m_mode   = M_IDLE;
            m_ov     = 1'b0;
            m_od     = 4'd0;
            m_cnt    = 0;
            m_halted = 1'b0;
        end else begin
            hit = 1'b0;
`ifdef STEP_BUDGET_EN
            hit = (m_mode == M_RUN) && !restart && (budget != 0) && (m_cnt == int'(budget));
`endif
            step = (m_mode == M_RUN) && !restart && in_valid && (!m_ov || out_ready) && !hit;
            check("m_in_ready",   32'(in_ready),   32'(step));
            check("m_dev_step",   32'(dev_step),   32'(step));
            check("m_out_valid",  32'(out_valid),  32'(m_ov));
            check("m_out_data",   32'(out_data),   32'(m_od));
            check("m_halted",     32'(halted),     32'(m_halted));
            check("m_step_count", 32'(step_count), 32'(m_cnt));
            check("m_busy",       32'(busy),       32'(m_mode == M_RUN));
            check("m_dev_rst",    32'(dev_rst),    32'(m_mode == M_DEVRST));
            check("m_dev_in",     32'(dev_in),     32'(in_data));
`ifdef STEP_BUDGET_EN
            check("m_budget_hit", 32'(budget_hit), 32'(hit));
`endif
            if (restart) begin
                m_mode = M_DEVRST; m_ov = 1'b0; m_cnt = 0; m_halted = 1'b0;
            end else begin
                if (step) begin
                    m_ov  = 1'b1;
                    m_od  = dev_out;
                    m_cnt = (m_cnt + 1) % (1 << CNT_W);
                    if (!dev_continue) begin
                        m_mode = M_HALTED; m_halted = 1'b1;
                    end
                end else if (out_ready) begin
                    m_ov = 1'b0;
                end
                if (m_mode == M_IDLE && start) m_mode = M_RUN;
                else if (m_mode == M_DEVRST) m_mode = M_RUN;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] sdata [4];
        sdata[0] = 4'h5; sdata[1] = 4'hA; sdata[2] = 4'h3; sdata[3] = 4'hC;
        rst = 1'b1; start = 1'b0; restart = 1'b0; in_valid = 1'b0; in_data = 4'd0;
        out_ready = 1'b0; budget = '0; halt_arm = 1'b0;

        // Reset and start
        cyc(); cyc();
        rst = 1'b0;
        #1;
        check("reset_step_count", 32'(step_count), 32'd0);
        check("reset_halted", 32'(halted), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_dev_rst", 32'(dev_rst), 32'd0);
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        #1;
        check("start_busy", 32'(busy), 32'd1);
        check("start_halted", 32'(halted), 32'd0);
        check("start_step_count", 32'(step_count), 32'd0);

        // Streaming: four back-to-back steps
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = sdata[i];
            #1;
            check("stream_dev_step", 32'(dev_step), 32'd1);
            cyc();
        end
        in_valid = 1'b0;
        #1;
        check("stream_out_data", 32'(out_data), 32'hF);
        check("stream_out_valid", 32'(out_valid), 32'd1);
        check("stream_step_count", 32'(step_count), 32'd4);
        cyc();
        check("stream_drained", 32'(out_valid), 32'd0);

        // Backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h6;
        #1;
        check("bp_first_step", 32'(dev_step), 32'd1);
        cyc();
        in_data = 4'h9;
        #1;
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_dev_step_low", 32'(dev_step), 32'd0);
        cyc();
        check("bp_held_data", 32'(out_data), 32'h2);
        check("bp_held_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp_release_step", 32'(dev_step), 32'd1);
        cyc();
        in_valid = 1'b0;
        #1;
        check("bp_new_data", 32'(out_data), 32'hC);
        check("bp_new_valid", 32'(out_valid), 32'd1);
        check("bp_step_count", 32'(step_count), 32'd6);
        cyc();

        // Restart has priority over a ready step
        restart = 1'b1; in_valid = 1'b1; in_data = 4'h0;
        #1;
        check("restart_blocks_step", 32'(dev_step), 32'd0);
        cyc();
        restart = 1'b0; in_valid = 1'b0;
        #1;
        check("devrst_dev_rst", 32'(dev_rst), 32'd1);
        check("devrst_step_count", 32'(step_count), 32'd0);
        cyc();
        check("devrst_one_cycle", 32'(dev_rst), 32'd0);
        check("devrst_then_run", 32'(busy), 32'd1);

        // Halt on the third step
        halt_arm = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        in_data = 4'h1; cyc();
        in_data = 4'h2; cyc();
        in_data = 4'h3; cyc();
        out_ready = 1'b0;
        #1;
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_busy", 32'(busy), 32'd0);
        check("halt_out_data", 32'(out_data), 32'h1);
        check("halt_step_count", 32'(step_count), 32'd3);
        check("halt_no_step", 32'(dev_step), 32'd0);
        check("halt_in_ready", 32'(in_ready), 32'd0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        #1;
        check("halt_start_ignored", 32'(busy), 32'd0);
        check("halt_out_valid", 32'(out_valid), 32'd1);

        // Restart from HALTED with a pending result
        restart = 1'b1; in_valid = 1'b0;
        cyc();
        restart = 1'b0; halt_arm = 1'b0;
        #1;
        check("rs_out_valid", 32'(out_valid), 32'd0);
        check("rs_dev_rst", 32'(dev_rst), 32'd1);
        check("rs_step_count", 32'(step_count), 32'd0);
        check("rs_halted", 32'(halted), 32'd0);
        cyc();
        check("rs_dev_rst_off", 32'(dev_rst), 32'd0);
        check("rs_run", 32'(busy), 32'd1);

        // Mixed traffic checked by the model, including counter wrap
        for (int i = 0; i < 60; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = 4'($urandom_range(0, 15));
            start     = ($urandom_range(0, 9) == 0);
            restart   = (i == 35);
            cyc();
        end
        start = 1'b0; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc();

`ifdef STEP_BUDGET_EN
        // Step budget
        restart = 1'b1; cyc(); restart = 1'b0; cyc();
        budget = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        #1;
        check("budget_count", 32'(step_count), 32'd2);
        check("budget_hit", 32'(budget_hit), 32'd1);
        budget = 3'd3;
        #1;
        check("budget_hit_clear", 32'(budget_hit), 32'd0);
        cyc(); cyc();
        check("budget_count3", 32'(step_count), 32'd3);
        check("budget_hit3", 32'(budget_hit), 32'd1);
        in_valid = 1'b0; budget = '0;
        cyc();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
